// File: rtl/sccb_config_sequencer.sv
// SCCB master that soft-resets an OV camera, waits for it to settle, then
// writes every {register, value} entry of a synchronous configuration ROM.
module sccb_config_sequencer #(
   parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
   parameter int unsigned SCCB_FREQ      = 100_000,
   parameter logic [7:0]  DEVICE_ID      = 8'h42,
   parameter int unsigned NUM_REGS       = 256,
   parameter int unsigned RESET_WAIT_CYC = 2_000_000
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        nack,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        scl,
   output logic        sda_oe,
   input  logic        sda_i
);

   localparam int unsigned QDIV   = SYS_CLK_FREQ / (4 * SCCB_FREQ);
   localparam int unsigned DIV_W  = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam int unsigned WAIT_W = (RESET_WAIT_CYC > 1) ? $clog2(RESET_WAIT_CYC) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(QDIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT_CYC - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [7:0]        LAST_ADDR = 8'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SRST_TX, S_SRST_WAIT, S_FETCH, S_CFG_TX, S_GAP, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        qtr_q, qtr_d;
   logic [4:0]        slot_q, slot_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fetch_q, fetch_d;
   logic [7:0]        reg_q, reg_d, val_q, val_d;
   logic [7:0]        rom_addr_q, rom_addr_d;
   logic              busy_q, busy_d, done_q, done_d, nack_q, nack_d;
   logic              scl_q, scl_d, sda_oe_q, sda_oe_d;
   logic              tick;

   assign tick = (div_q == DIV_LAST);

   // Bus levels {scl, sda_oe} for one quarter of a 29-slot write transaction.
   function automatic logic [1:0] tx_drive(input logic [4:0] slot, input logic [1:0] qtr,
                                           input logic [23:0] tx_bytes);
      logic [7:0] byte_v;
      logic [3:0] pos;
      logic [1:0] drv;
      byte_v = tx_bytes[23:16];
      pos    = 4'd0;
      drv    = 2'b10;
      if (slot == 5'd0) begin
         case (qtr)
            2'd0:    drv = 2'b10;
            2'd1:    drv = 2'b11;
            default: drv = 2'b01;
         endcase
      end else if (slot == 5'd28) begin
         case (qtr)
            2'd0:    drv = 2'b01;
            2'd1:    drv = 2'b11;
            default: drv = 2'b10;
         endcase
      end else begin
         if (slot <= 5'd9) begin
            byte_v = tx_bytes[23:16];
            pos    = 4'(slot - 5'd1);
         end else if (slot <= 5'd18) begin
            byte_v = tx_bytes[15:8];
            pos    = 4'(slot - 5'd10);
         end else begin
            byte_v = tx_bytes[7:0];
            pos    = 4'(slot - 5'd19);
         end
         drv[1] = qtr[1];
         if (pos == 4'd8) begin
            drv[0] = 1'b0;
         end else begin
            drv[0] = ~byte_v[3'd7 - pos[2:0]];
         end
      end
      return drv;
   endfunction

   // Next-state, counters and bus levels; bus levels follow the next state so they leave flops.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      qtr_d      = qtr_q;
      slot_d     = slot_q;
      wait_d     = wait_q;
      fetch_d    = fetch_q;
      reg_d      = reg_q;
      val_d      = val_q;
      rom_addr_d = rom_addr_q;
      busy_d     = busy_q;
      done_d     = done_q;
      nack_d     = nack_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_SRST_TX;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               nack_d     = 1'b0;
               rom_addr_d = 8'd0;
               div_d      = '0;
               qtr_d      = 2'd0;
               slot_d     = 5'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_SRST_TX, S_CFG_TX: begin
            // Only the address and register-byte ACKs count; the data-byte X bit is don't-care.
            if (tick && qtr_q == 2'd2 && (slot_q == 5'd9 || slot_q == 5'd18) && sda_i) begin
               nack_d = 1'b1;
            end else begin
               nack_d = nack_q;
            end
            if (tick) begin
               div_d = '0;
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3 && slot_q == 5'd28) begin
                  slot_d  = 5'd0;
                  wait_d  = '0;
                  state_d = (state_q == S_SRST_TX) ? S_SRST_WAIT : S_GAP;
               end else if (qtr_q == 2'd3) begin
                  slot_d = slot_q + 5'd1;
               end else begin
                  slot_d = slot_q;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         S_SRST_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = S_FETCH;
               fetch_d = 1'b0;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         S_FETCH: begin
            if (fetch_q) begin
               reg_d   = rom_data[15:8];
               val_d   = rom_data[7:0];
               state_d = S_CFG_TX;
               div_d   = '0;
               qtr_d   = 2'd0;
               slot_d  = 5'd0;
            end else begin
               fetch_d = 1'b1;
            end
         end
         S_GAP: begin
            if (tick) begin
               div_d = '0;
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3 && rom_addr_q == LAST_ADDR) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (qtr_q == 2'd3) begin
                  rom_addr_d = rom_addr_q + 8'd1;
                  state_d    = S_FETCH;
                  fetch_d    = 1'b0;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_SRST_TX: {scl_d, sda_oe_d} = tx_drive(slot_d, qtr_d, {DEVICE_ID, 8'h12, 8'h80});
         S_CFG_TX:  {scl_d, sda_oe_d} = tx_drive(slot_d, qtr_d, {DEVICE_ID, reg_d, val_d});
         default:   {scl_d, sda_oe_d} = 2'b10;
      endcase
   end

   // State and output registers; reset drops the bus to idle without a STOP.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         qtr_q      <= 2'd0;
         slot_q     <= 5'd0;
         wait_q     <= '0;
         fetch_q    <= 1'b0;
         reg_q      <= 8'd0;
         val_q      <= 8'd0;
         rom_addr_q <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         qtr_q      <= qtr_d;
         slot_q     <= slot_d;
         wait_q     <= wait_d;
         fetch_q    <= fetch_d;
         reg_q      <= reg_d;
         val_q      <= val_d;
         rom_addr_q <= rom_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         nack_q     <= nack_d;
         scl_q      <= scl_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign nack     = nack_q;
   assign rom_addr = rom_addr_q;
   assign scl      = scl_q;
   assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: a small-QDIV instance driven by a vector table,
// random ROM contents and a decoding slave model, plus a default-rate timing instance.
module tb_sccb_config_sequencer;

   localparam int QD_A = 2;
   localparam int W_A  = 10;
   localparam int N_A  = 2;
   localparam int QD_B = 250;
   localparam int W_B  = 200;
   localparam int N_B  = 1;

   logic        sys_clk = 1'b0;
   logic        rst_a, start_a, busy_a, done_a, nack_a, scl_a, oe_a, sda_i_a;
   logic [7:0]  addr_a;
   logic [15:0] rdata_a;
   logic        rst_b, start_b, busy_b, done_b, nack_b, scl_b, oe_b, sda_i_b;
   logic [7:0]  addr_b;
   logic [15:0] rdata_b;
   logic [15:0] rom_mem [0:255];
   longint      cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;
   always @(posedge sys_clk) rdata_a <= rom_mem[addr_a];
   always @(posedge sys_clk) rdata_b <= 16'h1234;

   sccb_config_sequencer #(.SYS_CLK_FREQ(100_000_000), .SCCB_FREQ(12_500_000), .DEVICE_ID(8'h42),
                           .NUM_REGS(N_A), .RESET_WAIT_CYC(W_A)) dut_a (
      .sys_clk(sys_clk), .rst_n(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
      .nack(nack_a), .rom_addr(addr_a), .rom_data(rdata_a), .scl(scl_a), .sda_oe(oe_a),
      .sda_i(sda_i_a));

   sccb_config_sequencer #(.NUM_REGS(N_B), .RESET_WAIT_CYC(W_B)) dut_b (
      .sys_clk(sys_clk), .rst_n(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
      .nack(nack_b), .rom_addr(addr_b), .rom_data(rdata_b), .scl(scl_b), .sda_oe(oe_b),
      .sda_i(sda_i_b));

   // Slave model: decodes START/bits/STOP on the open-drain line and drives ACKs.
   int          bitcnt = 99;
   bit          in_tx = 1'b0;
   bit          ack_drive = 1'b0;
   logic        prev_scl = 1'b1, prev_line = 1'b1;
   logic [23:0] sh = 24'd0;
   int          txn = 0;
   int          inj_tx = -1, inj_byte = 0;
   logic [23:0] got_q[$];
   longint      start_t[$], stop_t[$];

   assign sda_i_a = ~ack_drive;
   assign sda_i_b = 1'b0;

   always @(negedge sys_clk) begin : decode
      logic line;
      line = !(oe_a || ack_drive);
      if (scl_a && prev_scl && prev_line && !line) begin
         in_tx = 1'b1;
         bitcnt = 0;
         sh = 24'd0;
         start_t.push_back(cyc);
      end else if (scl_a && prev_scl && !prev_line && line) begin
         if (in_tx && bitcnt == 28) begin
            got_q.push_back(sh);
            stop_t.push_back(cyc);
            txn++;
         end
         in_tx = 1'b0;
      end else if (scl_a && !prev_scl) begin
         if (in_tx && bitcnt < 27 && (bitcnt % 9) != 8) sh = {sh[22:0], line};
         bitcnt++;
      end else if (!scl_a && prev_scl) begin
         ack_drive = in_tx && bitcnt < 27 && (bitcnt % 9) == 8 &&
                     !(txn == inj_tx && (bitcnt / 9 + 1) == inj_byte);
      end
      prev_scl  = scl_a;
      prev_line = !(oe_a || ack_drive);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // One full sequence on instance A, checked against the expected transaction list.
   task automatic run_seq(input logic [15:0] r0, input logic [15:0] r1, input int itx,
                          input int ibyte, input bit mid, input bit exp_nack, input string tag);
      longint      t0, el, exp_cyc;
      bit          seen;
      logic [23:0] exp_tx [3];
      rom_mem[0] = r0;
      rom_mem[1] = r1;
      inj_tx = itx;
      inj_byte = ibyte;
      got_q.delete();
      start_t.delete();
      stop_t.delete();
      txn = 0;
      ack_drive = 1'b0;
      exp_tx[0] = {8'h42, 8'h12, 8'h80};
      exp_tx[1] = {8'h42, r0};
      exp_tx[2] = {8'h42, r1};
      exp_cyc = 116 * QD_A + W_A + N_A * (2 + 116 * QD_A + 4 * QD_A);
      @(posedge sys_clk); #1 start_a = 1'b1;
      @(posedge sys_clk); #1 start_a = 1'b0;
      t0 = cyc;
      chk({tag, " busy_rise"}, busy_a, 1);
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         start_a = (mid && n == 300);
         @(posedge sys_clk); #1;
         if (done_a) seen = 1'b1;
      end
      start_a = 1'b0;
      el = cyc - t0;
      chk({tag, " done_seen"}, seen, 1);
      chk_range({tag, " total_cycles"}, el, exp_cyc - 4, exp_cyc + 4);
      chk({tag, " busy_end"}, busy_a, 0);
      chk({tag, " done_end"}, done_a, 1);
      chk({tag, " nack_end"}, nack_a, exp_nack);
      chk({tag, " rom_addr_end"}, addr_a, N_A - 1);
      chk({tag, " tx_count"}, got_q.size(), N_A + 1);
      for (int i = 0; i < 3; i++) begin
         if (i < got_q.size()) chk($sformatf("%s tx%0d_bytes", tag, i), got_q[i], exp_tx[i]);
      end
      if (start_t.size() >= 2 && stop_t.size() >= 1)
         chk_range({tag, " srst_idle"}, start_t[1] - stop_t[0], W_A, W_A + 100);
   endtask

   typedef struct {
      logic [15:0] r0;
      logic [15:0] r1;
      int          itx;
      int          ibyte;
      bit          mid;
      bit          exp_nack;
      string       tag;
   } vec_t;

   initial begin
      vec_t        vecs [5];
      logic [15:0] r0, r1;
      int          itx, ib;
      longint      t0, t_first, t_stop, t_done, exp_b;
      bit          pscl, poe, seen;
      vecs[0] = '{16'h1140, 16'h3A04, -1, 0, 1'b0, 1'b0, "basic"};
      vecs[1] = '{16'h1140, 16'h3A04, -1, 0, 1'b1, 1'b0, "start_busy"};
      vecs[2] = '{16'h1140, 16'h3A04,  1, 2, 1'b0, 1'b1, "nack_b2"};
      vecs[3] = '{16'h1140, 16'h3A04,  2, 3, 1'b0, 1'b0, "xbit_high"};
      vecs[4] = '{16'h1140, 16'h3A04,  0, 1, 1'b0, 1'b1, "nack_b1"};

      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst scl_a", scl_a, 1);
      chk("rst oe_a", oe_a, 0);
      chk("rst busy_a", busy_a, 0);
      chk("rst done_a", done_a, 0);
      chk("rst nack_a", nack_a, 0);
      chk("rst addr_a", addr_a, 0);
      chk("rst scl_b", scl_b, 1);
      chk("rst oe_b", oe_b, 0);
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;

      for (int v = 0; v < 5; v++)
         run_seq(vecs[v].r0, vecs[v].r1, vecs[v].itx, vecs[v].ibyte, vecs[v].mid,
                 vecs[v].exp_nack, vecs[v].tag);

      // Random ROM contents and random ACK faults; only byte-1/byte-2 ACKs may set nack.
      for (int k = 0; k < 6; k++) begin
         r0  = 16'($urandom);
         r1  = 16'($urandom);
         itx = int'($urandom_range(0, 3)) - 1;
         ib  = int'($urandom_range(1, 3));
         run_seq(r0, r1, itx, ib, 1'b0, (itx >= 0) && (ib != 3), $sformatf("rand%0d", k));
      end

      // Reset in the middle of the first configuration write.
      rom_mem[0] = 16'h1140;
      rom_mem[1] = 16'h3A04;
      inj_tx = -1;
      got_q.delete();
      txn = 0;
      ack_drive = 1'b0;
      @(posedge sys_clk); #1 start_a = 1'b1;
      @(posedge sys_clk); #1 start_a = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 1000 && !seen; n++) begin
         @(posedge sys_clk); #1;
         if (txn == 1 && bitcnt == 10) seen = 1'b1;
      end
      chk("midrst reached_bit10", seen, 1);
      rst_a = 1'b0;
      #1;
      chk("midrst scl", scl_a, 1);
      chk("midrst oe", oe_a, 0);
      chk("midrst busy", busy_a, 0);
      chk("midrst addr", addr_a, 0);
      repeat (3) @(posedge sys_clk);
      #1 rst_a = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      run_seq(16'h1140, 16'h3A04, -1, 0, 1'b0, 1'b0, "after_rst");

      // Default bus rate, one ROM entry: check START/STOP placement and overall length.
      @(posedge sys_clk); #1 start_b = 1'b1;
      @(posedge sys_clk); #1 start_b = 1'b0;
      t0 = cyc;
      t_first = -1; t_stop = -1; t_done = -1;
      pscl = scl_b; poe = oe_b;
      for (int n = 0; n < 70000 && t_done < 0; n++) begin
         @(posedge sys_clk); #1;
         if (t_first < 0 && oe_b) t_first = cyc - t0;
         if (t_stop < 0 && scl_b && pscl && poe && !oe_b) t_stop = cyc - t0;
         if (done_b) t_done = cyc - t0;
         pscl = scl_b;
         poe = oe_b;
      end
      exp_b = 116 * QD_B + W_B + N_B * (2 + 116 * QD_B + 4 * QD_B);
      chk("timing start_sda_fall", t_first, QD_B);
      chk("timing stop_release", t_stop, 114 * QD_B);
      chk_range("timing total", t_done, exp_b - 4, exp_b + 4);
      chk("timing busy_end", busy_b, 0);
      chk("timing nack_end", nack_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
